// File: rtl/cache_req_issuer.sv
// Request FIFO and bus sequencer in front of cache_controller; issues one request per cache_ready.
// Optional ISSUER_STATS_EN adds saturating read/write/filler completion counters.
module cache_req_issuer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_rw,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_rw,
  output logic [7:0]        resp_latency,
  output logic              err,
`ifdef ISSUER_STATS_EN
  output logic [15:0]       stat_reads,
  output logic [15:0]       stat_writes,
  output logic [15:0]       stat_fillers,
`endif
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_data_in,
  output logic              cache_rw,
  input  logic [DATA_W-1:0] cache_data_out,
  input  logic              cache_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [8:0] TO_CNT = 9'(TIMEOUT + 1);

  typedef enum logic [1:0] {S_SYNC, S_FILL, S_BUSY} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_rw   [DEPTH];

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [7:0]        lat_q, lat_d, lat_inc;
  logic [8:0]        lat_inc9;
  logic              err_q, err_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rrw_q, rrw_d;
  logic [7:0]        rlat_q, rlat_d;
  logic              full, empty, push;

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = req_valid && !full;

  assign req_ready     = !full;
  assign resp_valid    = rvalid_q;
  assign resp_rdata    = rdata_q;
  assign resp_rw       = rrw_q;
  assign resp_latency  = rlat_q;
  assign err           = err_q;
  assign cache_address = addr_q;
  assign cache_data_in = wdata_q;
  assign cache_rw      = rw_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q[PTR_W-1:0]] <= req_addr;
      mem_data[wr_ptr_q[PTR_W-1:0]] <= req_wdata;
      mem_rw[wr_ptr_q[PTR_W-1:0]]   <= req_rw;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    err_d    = err_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rrw_d    = rrw_q;
    rlat_d   = rlat_q;
    lat_inc  = (lat_q == 8'hFF) ? lat_q : lat_q + 8'd1;
    lat_inc9 = {1'b0, lat_q} + 9'd1;
    lat_d    = lat_inc;

    if (cache_ready) begin
      lat_d = 8'd0;
      if (state_q == S_BUSY) begin
        rvalid_d = 1'b1;
        rrw_d    = rw_q;
        rdata_d  = rw_q ? wdata_q : cache_data_out;
        rlat_d   = lat_inc;
      end
      if (!empty) begin
        addr_d   = mem_addr[rd_ptr_q[PTR_W-1:0]];
        wdata_d  = mem_data[rd_ptr_q[PTR_W-1:0]];
        rw_d     = mem_rw[rd_ptr_q[PTR_W-1:0]];
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        state_d  = S_BUSY;
      end else begin
        // filler re-reads the last issued address, which is known resident
        rw_d    = 1'b0;
        state_d = S_FILL;
      end
    end else if (lat_inc9 == TO_CNT) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_SYNC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      lat_q    <= 8'd0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rrw_q    <= 1'b0;
      rlat_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      lat_q    <= lat_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rrw_q    <= rrw_d;
      rlat_q   <= rlat_d;
    end
  end

`ifdef ISSUER_STATS_EN
  logic [15:0] srd_q, srd_d, swr_q, swr_d, sfl_q, sfl_d;

  assign stat_reads   = srd_q;
  assign stat_writes  = swr_q;
  assign stat_fillers = sfl_q;

  always_comb begin
    srd_d = srd_q;
    swr_d = swr_q;
    sfl_d = sfl_q;
    if (cache_ready) begin
      if (state_q != S_BUSY) begin
        if (sfl_q != 16'hFFFF) sfl_d = sfl_q + 16'd1;
      end else if (rw_q) begin
        if (swr_q != 16'hFFFF) swr_d = swr_q + 16'd1;
      end else begin
        if (srd_q != 16'hFFFF) srd_d = srd_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srd_q <= 16'd0;
      swr_q <= 16'd0;
      sfl_q <= 16'd0;
    end else begin
      srd_q <= srd_d;
      swr_q <= swr_d;
      sfl_q <= sfl_d;
    end
  end
`endif

endmodule

// File: tb/tb_cache_req_issuer.sv
// Randomized scoreboard bench for cache_req_issuer with a behavioural cache responder.
module tb_cache_req_issuer;
  localparam int DEPTH = 4, AW = 32, DW = 32, TIMEOUT = 63;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_rw, err;
  logic [DW-1:0] resp_rdata;
  logic [7:0]    resp_latency;
  logic [AW-1:0] cache_address;
  logic [DW-1:0] cache_data_in, cache_data_out;
  logic          cache_rw, cache_ready;
`ifdef ISSUER_STATS_EN
  logic [15:0]   stat_reads, stat_writes, stat_fillers;
`endif

  always #5 clk = ~clk;

  cache_req_issuer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rw(req_rw),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rw(resp_rw),
    .resp_latency(resp_latency), .err(err),
`ifdef ISSUER_STATS_EN
    .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_fillers(stat_fillers),
`endif
    .cache_address(cache_address), .cache_data_in(cache_data_in), .cache_rw(cache_rw),
    .cache_data_out(cache_data_out), .cache_ready(cache_ready)
  );

  typedef struct packed { logic [DW-1:0] rdata; logic rw; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] wr_mem [logic [AW-1:0]];
  logic [DW-1:0] cmem   [logic [AW-1:0]];

  int vectors = 0, fails = 0;
  int ncyc = 0, last_mark = 0, gap_tgt = 3, gmin = 2, gmax = 6, last_lat = 0;
  int resp_seen = 0, rd_done = 0, wr_done = 0;
  bit resp_en = 1'b0, err_exp = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // cache model: one-cycle ready pulses spaced gap_tgt cycles apart, fill pattern = address
  initial begin
    cache_ready    = 1'b0;
    cache_data_out = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      cache_ready    = 1'b0;
      cache_data_out = $urandom;
      if (rst) begin
        last_mark = ncyc - 1;
        err_exp   = 1'b0;
      end else if (resp_en && (ncyc - last_mark) >= gap_tgt) begin
        cache_ready = 1'b1;
        if (cache_rw) cmem[cache_address] = cache_data_in;
        else cache_data_out = cmem.exists(cache_address) ? cmem[cache_address] : cache_address;
        last_lat  = ((ncyc - last_mark) > 255) ? 255 : (ncyc - last_mark);
        last_mark = ncyc;
        gap_tgt   = $urandom_range(gmax, gmin);
      end else if ((ncyc - last_mark) >= TIMEOUT + 1) begin
        err_exp = 1'b1;
      end
    end
  end

  initial begin
    logic [AW+DW:0] prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {cache_address, cache_data_in, cache_rw};
      if (!rst) begin
        check("err_flag", 96'(err), 96'(err_exp));
        if (!cache_ready) check("bus_hold", 96'(cur), 96'(prev));
        if (resp_valid) begin
          resp_seen++;
          check("resp_expected", 96'(exp_q.size() != 0), 96'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("resp_rdata", 96'(resp_rdata), 96'(e.rdata));
            check("resp_rw", 96'(resp_rw), 96'(e.rw));
            check("resp_latency", 96'(resp_latency), 96'(last_lat));
            if (e.rw) wr_done++;
            else rd_done++;
          end
        end
      end
      prev = cur;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
    exp_t e;
    bit ok = 1'b0;
    req_addr  = a;
    req_wdata = d;
    req_rw    = rw;
    req_valid = 1'b1;
    for (int t = 0; t < 500 && !ok; t++) begin
      if (req_ready) begin
        ok = 1'b1;
        e.rw    = rw;
        e.rdata = rw ? d : (wr_mem.exists(a) ? wr_mem[a] : a);
        exp_q.push_back(e);
        if (rw) wr_mem[a] = d;
      end
      idle(1);
    end
    req_valid = 1'b0;
    check("push_accepted", 96'(ok), 96'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) idle(1);
    check("drain_empty", 96'(exp_q.size()), 96'(0));
  endtask

  task automatic check_reset();
    check("rst_req_ready", 96'(req_ready), 96'(1));
    check("rst_resp_valid", 96'(resp_valid), 96'(0));
    check("rst_resp_rdata", 96'(resp_rdata), 96'(0));
    check("rst_resp_rw", 96'(resp_rw), 96'(0));
    check("rst_resp_latency", 96'(resp_latency), 96'(0));
    check("rst_err", 96'(err), 96'(0));
    check("rst_cache_address", 96'(cache_address), 96'(0));
    check("rst_cache_data_in", 96'(cache_data_in), 96'(0));
    check("rst_cache_rw", 96'(cache_rw), 96'(0));
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_rw = 1'b0;
    idle(3);
    check_reset();
    rst = 1'b0;
    resp_en = 1'b1;

    push_req(32'h0000_1040, 32'hDEAD_BEEF, 1'b1);
    push_req(32'h0000_1040, 32'h0, 1'b0);
    drain();

    gmin = 25; gmax = 25;
    push_req(32'h0000_2000, 32'h0, 1'b0);
    drain();
    gmin = 2; gmax = 6;

    for (int i = 0; i < 60; i++) begin
      push_req(32'h0000_1000 + 32'(4 * $urandom_range(7, 0)), $urandom, 1'($urandom_range(1, 0)));
      idle($urandom_range(2, 0));
    end
    drain();

    resp_en = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) push_req(32'h0000_3000 + 32'(16 * i), $urandom, 1'(i % 2));
    check("full_req_ready", 96'(req_ready), 96'(0));
    resp_en = 1'b1;
    push_req(32'h0000_3040, 32'h0, 1'b0);
    push_req(32'h0000_3010, 32'h0, 1'b0);
    drain();

    for (int i = 0; i < 3; i++) push_req(32'h0000_1000 + 32'(4 * i), $urandom, 1'(i % 2));
    resp_en = 1'b0;
    idle(3);
    rst = 1'b1;
    #1;
    check_reset();
    exp_q.delete();
    wr_mem = cmem;
    rd_done = 0; wr_done = 0;
    idle(2);
    rst = 1'b0;
    resp_en = 1'b1;
    seen = resp_seen;
    idle(gap_tgt + 4);
    check("no_resp_after_reset", 96'(resp_seen), 96'(seen));

    for (int i = 0; i < 3; i++) push_req(32'h0000_1000 + 32'(4 * i), 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) push_req(32'h0000_1100 + 32'(4 * i), $urandom, 1'b1);
    drain();
`ifdef ISSUER_STATS_EN
    check("stat_reads", 96'(stat_reads), 96'(rd_done));
    check("stat_writes", 96'(stat_writes), 96'(wr_done));
    check("stat_fillers_nonzero", 96'(stat_fillers != 16'd0), 96'(1));
`endif

    gmin = 300; gmax = 300;
    push_req(32'h0000_1100, 32'h0, 1'b0);
    drain();
    check("err_sticky", 96'(err), 96'(1));
    resp_en = 1'b0;
    idle(80);
    check("err_still_set", 96'(err), 96'(1));
    rst = 1'b1;
    #1;
    check("err_cleared_by_rst", 96'(err), 96'(0));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

endmodule
